// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative RV32M multiply/divide unit living beside the EX-stage ALU.
//   One operation is in flight at a time. Multiplies use a radix-2
//   shift-add core and divides use a restoring core. Both cores share one
//   2*XLEN accumulator. Signed operands are reduced to magnitudes when the
//   operation is accepted. The sign is restored in the final CALC cycle.
//
//   Handshakes (valid/ready):
//     - A transfer happens on a rising edge where valid and ready are both
//       high.
//     - in_ready depends on state only. It is high only in IDLE.
//     - out_valid stays high, with out_result and out_tag stable, until
//       out_ready is seen.
//     - flush takes priority over both handshakes.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   flush             kill any in-flight op; nothing is accepted that cycle
//   in_valid/in_ready request handshake
//   in_op             funct3: MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//   in_a, in_b        rs1 / rs2 operands
//   in_tag            destination tag, returned unchanged with the result
//   out_valid/ready   result handshake
//   out_result        result
//   out_tag           tag of the result
//   busy              state != IDLE
//   dbg_state         current FSM state (0 IDLE, 1 CALC, 2 DONE)
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic [2:0]        r_op;
    logic              r_neg;      // final result must be negated
    logic [CNT_W-1:0]  r_cnt;
    logic [2*XLEN-1:0] r_acc;      // mul: {hi, lo} product; div: {rem, quo}
    logic [XLEN-1:0]   r_opb;      // multiplicand / divisor magnitude
    logic [XLEN-1:0]   r_result;
    logic [TAG_W-1:0]  r_tag;

    // ------------------------------------------------------------------
    // Request decode (used only on the accept edge)
    // ------------------------------------------------------------------
    logic            w_accept;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_neg;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;

    assign w_accept   = (r_state == S_IDLE) && in_valid && !flush;

    // Unsigned operands: MULHU, DIVU, REMU for a; additionally MULHSU for b.
    assign w_a_signed = (in_op != 3'b011) && (in_op != 3'b101) && (in_op != 3'b111);
    assign w_b_signed = (in_op == 3'b000) || (in_op == 3'b001) ||
                        (in_op == 3'b100) || (in_op == 3'b110);
    assign w_a_neg    = w_a_signed && in_a[XLEN-1];
    assign w_b_neg    = w_b_signed && in_b[XLEN-1];
    assign w_a_mag    = w_a_neg ? -in_a : in_a;
    assign w_b_mag    = w_b_neg ? -in_b : in_b;

    // REM takes the dividend's sign. Every other op uses the xor of the
    // operand signs. An unsigned operand contributes 0.
    assign w_neg      = (in_op == 3'b110) ? w_a_neg : (w_a_neg ^ w_b_neg);

    assign w_div_zero = in_op[2] && (in_b == '0);
    assign w_ovf      = ((in_op == 3'b100) || (in_op == 3'b110)) &&
                        (in_a == MIN_INT) && (in_b == ALL_ONES);
    assign w_special  = w_div_zero || w_ovf;

    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = in_op[1] ? in_a : ALL_ONES;
        end else if (w_ovf) begin
            w_special_res = in_op[1] ? '0 : MIN_INT;
        end
    end

    // ------------------------------------------------------------------
    // One iteration of the shared core
    // ------------------------------------------------------------------
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN+1:0]   w_diff;
    logic [2*XLEN-1:0] w_div_next;
    logic [2*XLEN-1:0] w_acc_next;

    // Multiply: add the multiplicand into the high half when the low
    // multiplier bit is set, then shift the whole accumulator right.
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                        (r_acc[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // Restoring divide: shift the next dividend bit into the remainder and
    // trial-subtract. The extra top bit of w_diff is the borrow.
    assign w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_diff     = {1'b0, w_rem_sh} - {2'b00, r_opb};
    assign w_div_next = w_diff[XLEN+1] ?
                        {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0} :
                        {w_diff[XLEN-1:0],   r_acc[XLEN-2:0], 1'b1};

    assign w_acc_next = r_op[2] ? w_div_next : w_mul_next;

    // Sign fix and result select, applied to the output of the last iteration.
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_div_pick;
    logic [XLEN-1:0]   w_div_fix;
    logic [XLEN-1:0]   w_final;

    assign w_prod_fix = r_neg ? -w_acc_next : w_acc_next;
    assign w_div_pick = r_op[1] ? w_acc_next[2*XLEN-1:XLEN] : w_acc_next[XLEN-1:0];
    assign w_div_fix  = r_neg ? -w_div_pick : w_div_pick;
    assign w_final    = r_op[2] ? w_div_fix :
                        ((r_op == 3'b000) ? w_prod_fix[XLEN-1:0] :
                                            w_prod_fix[2*XLEN-1:XLEN]);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (w_accept) begin
                    w_next_state = w_special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                // The cycle that brings the counter to zero is the last
                // iteration.
                if (r_cnt == CNT_W'(1)) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        if (flush) begin
            w_next_state = S_IDLE;
        end
    end

    assign out_result = r_result;
    assign out_tag    = r_tag;
    assign dbg_state  = r_state;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_result <= '0;
            r_tag    <= '0;
        end else if (w_accept) begin
            r_op  <= in_op;
            r_neg <= w_neg;
            r_tag <= in_tag;
            r_cnt <= CNT_W'(XLEN);
            r_acc <= {{XLEN{1'b0}}, w_a_mag};
            r_opb <= w_b_mag;
            if (w_special) begin
                r_result <= w_special_res;
            end
        end else if ((r_state == S_CALC) && !flush) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                r_result <= w_final;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam int W     = TAG_W + XLEN;

  // ---------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------
  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  int n_vec = 0;
  int n_err = 0;
  bit rdy_force = 1'b1;
  bit rdy_val   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: RV32M results from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    longint q;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        q = longint'($signed(a)) / longint'($signed(b));
        return q[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        q = longint'($signed(a)) % longint'($signed(b));
        return q[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 15));
      4: return 32'h7FFFFFFF;
      default: return $urandom();
    endcase
  endfunction

  // ---------------------------------------------------------------
  // out_ready driver: directed phases force it, random phase toggles it
  // ---------------------------------------------------------------
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------------------------------------------------------
  // Monitor: pops and compares on every result handshake
  // ---------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got tag %0d result 0x%0h, none expected", out_tag, out_result);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", 64'(out_result), 64'(mon_exp[XLEN-1:0]));
        check("tag", 64'(out_tag), 64'(mon_exp[W-1:XLEN]));
      end
    end
  end

  // ---------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input bit push);
    int g;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("issue_ready", 64'(in_ready), 64'd1);
    if (!in_ready) return;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (push) exp_q.push_back({tag, ref_model(op, a, b)});
  endtask

  // Counts rising edges from the accept edge (inclusive) until out_valid.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    do begin
      @(posedge clk);
      #1;
      g++;
    end while (busy && g < 300);
    check("idle", 64'(busy), 64'd0);
  endtask

  task automatic directed(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag,
                          input logic [31:0] exp_res, input int exp_lat);
    int lat;
    rdy_force = 1'b1;
    rdy_val   = 1'b0;
    issue(op, a, b, tag, 1'b1);
    wait_valid(lat);
    check({name, "_lat"}, 64'(lat), 64'(exp_lat));
    check({name, "_res"}, 64'(out_result), 64'(exp_res));
    check({name, "_tag"}, 64'(out_tag), 64'(tag));
    rdy_val = 1'b1;
    wait_idle();
  endtask

  // ---------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------
  logic [2:0]  r_op_v;
  logic [31:0] r_a_v;
  logic [31:0] r_b_v;
  logic [31:0] bp_exp;
  int          lat_v;
  int          g_v;

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_op    = '0;
    in_a     = '0;
    in_b     = '0;
    in_tag   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_result", 64'(out_result), 64'd0);
    check("rst_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases with known answers
    directed("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 5'd17, 32'hFFFFFFEB, 33);
    directed("mulh",   3'd1, 32'h80000000, 32'h80000000, 5'd1,  32'h40000000, 33);
    directed("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 33);
    directed("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2,        5'd3,  32'hFFFFFFFF, 33);
    directed("div_ovf",3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd4,  32'h80000000, 1);
    directed("rem_ovf",3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd5,  32'h00000000, 1);
    directed("divu_z", 3'd5, 32'd123,      32'd0,        5'd6,  32'hFFFFFFFF, 1);
    directed("remu_z", 3'd7, 32'd123,      32'd0,        5'd7,  32'd123,      1);
    directed("div_neg",3'd4, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFD, 33);
    directed("rem_neg",3'd6, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFF, 33);

    // Back-pressure: result held stable for 10 cycles
    rdy_force = 1'b1;
    rdy_val   = 1'b0;
    r_a_v  = $urandom();
    r_b_v  = $urandom();
    bp_exp = ref_model(3'd3, r_a_v, r_b_v);
    issue(3'd3, r_a_v, r_b_v, 5'd21, 1'b1);
    wait_valid(lat_v);
    check("bp_lat", 64'(lat_v), 64'd33);
    repeat (10) begin
      @(posedge clk);
      #1;
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_result", 64'(out_result), 64'(bp_exp));
      check("bp_tag", 64'(out_tag), 64'd21);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    rdy_val = 1'b1;
    @(negedge clk);
    check("bp_ready_cycle_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    check("bp_release_valid", 64'(out_valid), 64'd0);

    // Flush during CALC, then a fresh multiply
    rdy_val = 1'b0;
    issue(3'd0, 32'd100, 32'd200, 5'd30, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    directed("post_flush_mul", 3'd0, 32'd3, 32'd4, 5'd10, 32'd12, 33);

    // Flush together with in_valid in IDLE: nothing accepted
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_op    = 3'd0;
    in_a     = 32'd5;
    in_b     = 32'd5;
    in_tag   = 5'd11;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush_idle_busy", 64'(busy), 64'd0);
    check("flush_idle_state", 64'(dbg_state), 64'd0);

    // Reset in the middle of a divide
    issue(3'd5, $urandom(), 32'd7, 5'd12, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_result", 64'(out_result), 64'd0);
    check("midrst_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic with random back-pressure
    rdy_force = 1'b0;
    for (int i = 0; i < 60; i++) begin
      r_op_v = 3'($urandom_range(0, 7));
      r_a_v  = rand_opnd();
      r_b_v  = rand_opnd();
      issue(r_op_v, r_a_v, r_b_v, 5'(i), 1'b1);
    end
    g_v = 0;
    while (exp_q.size() != 0 && g_v < 3000) begin
      @(posedge clk);
      g_v++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
